// File: rtl/adc_seq_pkg.sv
// Shared types for the ADC scan sequencer: scheduler states, result tag and default NOP word.
package adc_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CFG   = 2'd1,
    SCAN  = 2'd2,
    DRAIN = 2'd3
  } seq_state_t;

  // Tag channel field is sized for the largest supported channel count; users keep the low CH_W bits.
  localparam int TAG_CH_W = 8;

  typedef struct packed {
    logic                valid;
    logic                host;
    logic [TAG_CH_W-1:0] ch;
  } tag_t;

  localparam logic [15:0] NOP_WORD_DEF = 16'h0000;

endpackage

// File: rtl/adc_scan_sequencer_if.sv
// Command and result links between the scan sequencer (master) and the ADC frame engine (slave).
interface adc_scan_sequencer_if;
  // cmd: a word transfers on any sclk edge where cmd_valid && cmd_ready; cmd_word holds until then.
  // res: res_valid is a single-cycle pulse qualifying res_data; there is no backpressure.
  logic        cmd_valid;
  logic [15:0] cmd_word;
  logic        cmd_ready;
  logic        res_valid;
  logic [15:0] res_data;

  modport master (
    output cmd_valid, cmd_word,
    input  cmd_ready, res_valid, res_data
  );

  modport slave (
    input  cmd_valid, cmd_word,
    output cmd_ready, res_valid, res_data
  );
endinterface

// File: rtl/adc_tag_pipe.sv
// Tag shift register matching the ADC conversion latency; the oldest stage tags each returned result.
module adc_tag_pipe
  import adc_seq_pkg::*;
#(
  parameter int LATENCY = 2
) (
  input  logic sclk,
  input  logic rst,
  input  logic shift,
  input  tag_t tag_in,
  input  logic res_valid,
  output tag_t res_tag,
  output logic res_hit,
  output logic res_drop
);

  tag_t stage_q [LATENCY+1];

  always_ff @(posedge sclk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i <= LATENCY; i++) stage_q[i] <= '0;
    end else if (shift) begin
      stage_q[0] <= tag_in;
      for (int i = 1; i <= LATENCY; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  // Lookup reads the registered stage, so a result coinciding with a shift sees the pre-shift tag.
  assign res_tag  = stage_q[LATENCY];
  assign res_hit  = res_valid & res_tag.valid;
  assign res_drop = res_valid & ~res_tag.valid;

endmodule

// File: rtl/adc_scan_sequencer.sv
// ADC command scheduler: config word, round-robin channel scan with host insertion, result tagging.
// Optional ADC_SCAN_SEQ_STATS_EN adds saturating stat_drop / stat_host counters.
module adc_scan_sequencer
  import adc_seq_pkg::*;
#(
  parameter int          NUM_CH   = 8,
  parameter int          CH_W     = 3,
  parameter int          CH_LSB   = 7,
  parameter int          LATENCY  = 2,
  parameter logic [15:0] NOP_WORD = NOP_WORD_DEF
) (
  input  logic                sclk,
  input  logic                rst,
  input  logic                enable,
  input  logic [15:0]         cfg_word,
  input  logic [NUM_CH-1:0]   ch_mask,
  input  logic                host_req,
  input  logic [15:0]         host_word,
  output logic                host_ack,
  adc_scan_sequencer_if.master adc,
  output logic                out_valid,
  output logic [15:0]         out_data,
  output logic [CH_W-1:0]     out_ch,
  output logic                out_host,
  output logic                busy,
  output logic                seq_err,
`ifdef ADC_SCAN_SEQ_STATS_EN
  output logic [15:0]         stat_drop,
  output logic [15:0]         stat_host,
`endif
  output seq_state_t          dbg_state
);

  localparam int DRAIN_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(LATENCY - 1);
  localparam int FILL_W = $clog2(LATENCY + 2);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(LATENCY + 1);

  seq_state_t        state_q, state_d;
  logic              cmd_valid_q;
  logic [15:0]       cmd_word_q, cmd_word_d;
  tag_t              tag_q, tag_d;
  logic              host_q, host_d;
  logic [CH_W-1:0]   ptr_q, ptr_d;
  logic [DRAIN_W-1:0] drain_q, drain_d;
  logic              hs;
  logic              load_cfg, pick_host, pick_scan;
  logic              scan_hit;
  logic [CH_W-1:0]   scan_ch, scan_cand;
  logic [15:0]       scan_word;
  tag_t              res_tag;
  logic              res_hit, res_drop;
  logic              res_seen_q;
  logic [FILL_W-1:0] fill_q;
  logic              err_set;

  assign hs            = cmd_valid_q & adc.cmd_ready;
  assign adc.cmd_valid = cmd_valid_q;
  assign adc.cmd_word  = cmd_word_q;
  // host_q marks that the word on offer is a host word, so the ack lands on its own transfer.
  assign host_ack      = hs & host_q;
  assign busy          = (state_q != IDLE);
  assign dbg_state     = state_q;

  // Next set mask bit strictly after ptr_q, wrapping; the smallest offset wins.
  always_comb begin
    scan_hit  = 1'b0;
    scan_ch   = ptr_q;
    scan_cand = '0;
    for (int i = NUM_CH; i >= 1; i--) begin
      scan_cand = CH_W'((int'(ptr_q) + i) % NUM_CH);
      if (ch_mask[scan_cand]) begin
        scan_hit = 1'b1;
        scan_ch  = scan_cand;
      end
    end
  end

  always_comb begin
    scan_word                   = cfg_word;
    scan_word[CH_LSB +: CH_W]   = scan_ch;
  end

  // Everything below only moves at a handshake: it picks the word for the following frame.
  always_comb begin
    state_d    = state_q;
    cmd_word_d = cmd_word_q;
    tag_d      = tag_q;
    host_d     = host_q;
    ptr_d      = ptr_q;
    drain_d    = drain_q;
    load_cfg   = 1'b0;
    pick_host  = 1'b0;
    pick_scan  = 1'b0;
    if (hs) begin
      cmd_word_d = NOP_WORD;
      tag_d      = '0;
      host_d     = 1'b0;
      unique case (state_q)
        IDLE: begin
          if (enable) begin
            state_d  = CFG;
            load_cfg = 1'b1;
          end else begin
            pick_host = 1'b1;
          end
        end
        CFG: begin
          state_d   = SCAN;
          pick_host = 1'b1;
          pick_scan = 1'b1;
        end
        SCAN: begin
          if (!enable) begin
            state_d = DRAIN;
            drain_d = '0;
          end else begin
            pick_host = 1'b1;
            pick_scan = 1'b1;
          end
        end
        DRAIN: begin
          if (enable) begin
            state_d  = CFG;
            load_cfg = 1'b1;
          end else if (drain_q == DRAIN_LAST) begin
            state_d = IDLE;
          end else begin
            drain_d = drain_q + 1'b1;
          end
        end
      endcase

      if (load_cfg) begin
        cmd_word_d = cfg_word;
        tag_d.valid = 1'b1;
        tag_d.host  = 1'b1;
        ptr_d      = CH_W'(NUM_CH - 1);
      end else if (pick_host && host_req && !host_q) begin
        cmd_word_d  = host_word;
        tag_d.valid = 1'b1;
        tag_d.host  = 1'b1;
        host_d      = 1'b1;
      end else if (pick_scan && scan_hit) begin
        cmd_word_d         = scan_word;
        tag_d.valid        = 1'b1;
        tag_d.ch[CH_W-1:0] = scan_ch;
        ptr_d              = scan_ch;
      end
    end
  end

  always_ff @(posedge sclk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cmd_valid_q <= 1'b0;
      cmd_word_q  <= NOP_WORD;
      tag_q       <= '0;
      host_q      <= 1'b0;
      ptr_q       <= CH_W'(NUM_CH - 1);
      drain_q     <= '0;
    end else begin
      state_q     <= state_d;
      cmd_valid_q <= 1'b1;
      cmd_word_q  <= cmd_word_d;
      tag_q       <= tag_d;
      host_q      <= host_d;
      ptr_q       <= ptr_d;
      drain_q     <= drain_d;
    end
  end

  adc_tag_pipe #(.LATENCY(LATENCY)) u_tag_pipe (
    .sclk      (sclk),
    .rst       (rst),
    .shift     (hs),
    .tag_in    (tag_q),
    .res_valid (adc.res_valid),
    .res_tag   (res_tag),
    .res_hit   (res_hit),
    .res_drop  (res_drop)
  );

  // A result coinciding with a handshake belongs to the interval before that handshake.
  assign err_set = (adc.res_valid & res_seen_q) |
                   (hs & (fill_q == FILL_MAX) & ~(res_seen_q | adc.res_valid));

  always_ff @(posedge sclk or posedge rst) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_ch     <= '0;
      out_host   <= 1'b0;
      res_seen_q <= 1'b0;
      fill_q     <= '0;
      seq_err    <= 1'b0;
    end else begin
      out_valid <= res_hit;
      if (res_hit) begin
        out_data <= adc.res_data;
        out_ch   <= res_tag.ch[CH_W-1:0];
        out_host <= res_tag.host;
      end
      res_seen_q <= hs ? 1'b0 : (res_seen_q | adc.res_valid);
      if (hs && (fill_q != FILL_MAX)) fill_q <= fill_q + 1'b1;
      if (err_set) seq_err <= 1'b1;
    end
  end

`ifdef ADC_SCAN_SEQ_STATS_EN
  always_ff @(posedge sclk or posedge rst) begin
    if (rst) begin
      stat_drop <= '0;
      stat_host <= '0;
    end else begin
      if (res_drop && (stat_drop != 16'hFFFF)) stat_drop <= stat_drop + 16'd1;
      if (host_ack && (stat_host != 16'hFFFF)) stat_host <= stat_host + 16'd1;
    end
  end
`endif

endmodule
